// File: rtl/alu_md_stage.sv
// rtl/alu_md_stage.sv - single-cycle ALU with optional iterative divider (ALU_MD_STAGE_DIV_EN)
module alu_md_stage #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [XLEN-1:0]  a,
    input  logic [XLEN-1:0]  b,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  result,
    output logic [2:0]       cmp,
    output logic [TAG_W-1:0] tag_out,
    output logic             err,
    output logic             busy
);
    localparam int SH_W = $clog2(XLEN);

    logic            out_free;
    logic            accept;
    logic            idle;
    logic            start_div;
    logic            sc_err;
    logic [XLEN-1:0] sc_result;
    logic [2:0]      cmp_c;
    logic [SH_W-1:0] shamt;

    assign out_free = ~out_valid | out_ready;
    assign in_ready = idle & out_free;
    assign accept   = in_valid & in_ready;
    assign cmp_c    = {a == b, $signed(a) < $signed(b), a < b};
    assign shamt    = b[SH_W-1:0];

`ifdef ALU_MD_STAGE_DIV_EN
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_FIX} state_t;
    state_t state;

    logic [XLEN-1:0]  rem_q;
    logic [XLEN-1:0]  quot_q;
    logic [XLEN-1:0]  dvs_q;
    logic [SH_W-1:0]  cnt;
    logic             neg_q;
    logic             neg_r;
    logic             is_rem;
    logic             fix_done;
    logic [2:0]       cmp_p;
    logic [TAG_W-1:0] tag_p;
    logic [XLEN-1:0]  a_mag;
    logic [XLEN-1:0]  b_mag;
    logic [XLEN:0]    shifted;
    logic [XLEN:0]    diff;

    // op[0] set means the unsigned variant, so signed magnitudes only when it is clear
    assign a_mag   = (~op[0] & a[XLEN-1]) ? -a : a;
    assign b_mag   = (~op[0] & b[XLEN-1]) ? -b : b;
    assign shifted = {rem_q, quot_q[XLEN-1]};
    assign diff    = shifted - {1'b0, dvs_q};
    assign idle    = (state == S_IDLE);
    assign busy    = (state != S_IDLE);
`else
    assign idle    = 1'b1;
    assign busy    = 1'b0;
`endif

    always_comb begin
        sc_result = '0;
        sc_err    = 1'b0;
        start_div = 1'b0;
        case (op)
            4'd0:  sc_result = a + b;
            4'd1:  sc_result = a - b;
            4'd2:  sc_result = a << shamt;
            4'd3:  sc_result = {{(XLEN-1){1'b0}}, cmp_c[1]};
            4'd4:  sc_result = {{(XLEN-1){1'b0}}, cmp_c[0]};
            4'd5:  sc_result = a ^ b;
            4'd6:  sc_result = a >> shamt;
            4'd7:  sc_result = $unsigned($signed(a) >>> shamt);
            4'd8:  sc_result = a | b;
            4'd9:  sc_result = a & b;
            4'd10, 4'd11, 4'd12, 4'd13: begin
`ifdef ALU_MD_STAGE_DIV_EN
                // op[2] selects remainder; corner cases bypass the iterative path
                if (b == '0)
                    sc_result = op[2] ? a : '1;
                else if (~op[0] && a == MIN_NEG && b == '1)
                    sc_result = op[2] ? '0 : a;
                else
                    start_div = 1'b1;
`else
                sc_err = 1'b1;
`endif
            end
            default: sc_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            out_valid <= 1'b0;
            result    <= '0;
            cmp       <= '0;
            tag_out   <= '0;
            err       <= 1'b0;
`ifdef ALU_MD_STAGE_DIV_EN
            state     <= S_IDLE;
            cnt       <= '0;
            fix_done  <= 1'b0;
`endif
        end else begin
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            if (accept && !start_div) begin
                out_valid <= 1'b1;
                result    <= sc_result;
                cmp       <= cmp_c;
                tag_out   <= tag_in;
                err       <= sc_err;
            end
`ifdef ALU_MD_STAGE_DIV_EN
            case (state)
                S_IDLE: begin
                    if (accept && start_div) begin
                        state  <= S_DIV;
                        cnt    <= '0;
                        rem_q  <= '0;
                        quot_q <= a_mag;
                        dvs_q  <= b_mag;
                        neg_q  <= ~op[0] & (a[XLEN-1] ^ b[XLEN-1]);
                        neg_r  <= ~op[0] & a[XLEN-1];
                        is_rem <= op[2];
                        cmp_p  <= cmp_c;
                        tag_p  <= tag_in;
                    end
                end
                S_DIV: begin
                    // restoring step: a borrow out of diff means the trial subtract failed
                    if (!diff[XLEN]) begin
                        rem_q  <= diff[XLEN-1:0];
                        quot_q <= {quot_q[XLEN-2:0], 1'b1};
                    end else begin
                        rem_q  <= shifted[XLEN-1:0];
                        quot_q <= {quot_q[XLEN-2:0], 1'b0};
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == SH_W'(XLEN-1)) begin
                        state    <= S_FIX;
                        fix_done <= 1'b0;
                    end
                end
                S_FIX: begin
                    if (!fix_done) begin
                        quot_q   <= neg_q ? -quot_q : quot_q;
                        rem_q    <= neg_r ? -rem_q : rem_q;
                        fix_done <= 1'b1;
                    end else if (out_free) begin
                        out_valid <= 1'b1;
                        result    <= is_rem ? rem_q : quot_q;
                        cmp       <= cmp_p;
                        tag_out   <= tag_p;
                        err       <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
`endif
        end
    end
endmodule
